axi_rd_arbiter: RTL and testbench



---
 rtl/axi_rd_arbiter.sv | 70 +++++++
 tb/tb_axi_rd_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin two-master AXI-lite read arbiter (AR/R) with one outstanding read.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready
);
    localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
    logic [1:0] state;
    logic       grant, last;
    logic       in_addr, in_data, sel0, sel1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (m0_arvalid || m1_arvalid) begin
                    // on a tie the master not served last goes first
                    grant <= (m0_arvalid && m1_arvalid) ? ~last : m1_arvalid;
                    state <= ADDR;
                end
                ADDR: if (s_arvalid && s_arready) state <= DATA;
                DATA: if (s_rvalid && s_rready) begin
                    last  <= grant;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign in_addr    = state == ADDR;
    assign in_data    = state == DATA;
    assign sel0       = !grant;
    assign sel1       = grant;
    assign s_araddr   = in_addr ? (grant ? m1_araddr : m0_araddr) : '0;
    assign s_arvalid  = in_addr && (grant ? m1_arvalid : m0_arvalid);
    assign m0_arready = in_addr && sel0 && s_arready;
    assign m1_arready = in_addr && sel1 && s_arready;
    assign s_rready   = in_data && (grant ? m1_rready : m0_rready);
    assign m0_rvalid  = in_data && sel0 && s_rvalid;
    assign m1_rvalid  = in_data && sel1 && s_rvalid;
    assign m0_rdata   = (in_data && sel0) ? s_rdata : '0;
    assign m1_rdata   = (in_data && sel1) ? s_rdata : '0;
    assign m0_rresp   = (in_data && sel0) ? s_rresp : '0;
    assign m1_rresp   = (in_data && sel1) ? s_rresp : '0;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed checks of grant order, stalls, response pass-through and async reset.
module tb_axi_rd_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] m0_araddr = '0, m1_araddr = '0, s_rdata = '0;
    logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0, m0_rready = 1'b1, m1_rready = 1'b1;
    logic        s_arready = 1'b0, s_rvalid = 1'b0;
    logic [1:0]  s_rresp = '0;
    logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready;
    logic [31:0] m0_rdata, m1_rdata, s_araddr;
    logic [1:0]  m0_rresp, m1_rresp;
    int vec = 0, err = 0;

    axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        rst = 1'b1;
        m0_arvalid = 0; m1_arvalid = 0; m0_araddr = '0; m1_araddr = '0;
        m0_rready = 1; m1_rready = 1; s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Plays the slave for one read; entered at the negedge of the first ADDR cycle.
    task automatic slave_txn(input bit g, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp, input int ar_wait, input int r_wait, input bit again);
        logic [1:0] want = g ? 2'b10 : 2'b01;
        for (int i = 0; i < ar_wait; i++) begin
            #1;
            vec++; if (s_arvalid !== 1'b1 || s_araddr !== addr) begin err++; $display("FAIL ar_stall: s_arvalid=%b s_araddr=%h, want 1 %h", s_arvalid, s_araddr, addr); end
            vec++; if ({m1_arready, m0_arready} !== 2'b00) begin err++; $display("FAIL ar_stall_ready: arready=%b, want 00", {m1_arready, m0_arready}); end
            @(negedge clk);
        end
        s_arready = 1; #1;
        vec++; if (s_arvalid !== 1'b1 || s_araddr !== addr) begin err++; $display("FAIL ar_fwd: s_arvalid=%b s_araddr=%h, want 1 %h", s_arvalid, s_araddr, addr); end
        vec++; if ({m1_arready, m0_arready} !== want) begin err++; $display("FAIL ar_grant: arready=%b, want %b", {m1_arready, m0_arready}, want); end
        @(negedge clk);
        s_arready = 0;
        if (g) m1_arvalid = again; else m0_arvalid = again;
        s_rvalid = 1; s_rdata = data; s_rresp = resp;
        if (r_wait > 0) begin if (g) m1_rready = 0; else m0_rready = 0; end
        for (int i = 0; i < r_wait; i++) begin
            #1;
            vec++; if ({m1_rvalid, m0_rvalid} !== want || s_rready !== 1'b0 || s_arvalid !== 1'b0) begin err++; $display("FAIL r_stall: rvalid=%b s_rready=%b s_arvalid=%b, want %b 0 0", {m1_rvalid, m0_rvalid}, s_rready, s_arvalid, want); end
            vec++; if ((g ? m1_rdata : m0_rdata) !== data) begin err++; $display("FAIL r_stall_data: rdata=%h, want %h", g ? m1_rdata : m0_rdata, data); end
            @(negedge clk);
        end
        m0_rready = 1; m1_rready = 1; #1;
        vec++; if ({m1_rvalid, m0_rvalid} !== want || s_rready !== 1'b1 || s_arvalid !== 1'b0) begin err++; $display("FAIL r_hs: rvalid=%b s_rready=%b s_arvalid=%b, want %b 1 0", {m1_rvalid, m0_rvalid}, s_rready, s_arvalid, want); end
        vec++; if ((g ? m1_rdata : m0_rdata) !== data || (g ? m1_rresp : m0_rresp) !== resp) begin err++; $display("FAIL r_data: rdata=%h rresp=%b, want %h %b", g ? m1_rdata : m0_rdata, g ? m1_rresp : m0_rresp, data, resp); end
        vec++; if ((g ? m0_rdata : m1_rdata) !== 32'h0) begin err++; $display("FAIL r_other: other rdata=%h, want 0", g ? m0_rdata : m1_rdata); end
        @(negedge clk);
        s_rvalid = 0; s_rdata = '0; s_rresp = '0; #1;
        vec++; if (s_arvalid !== 1'b0 || {m1_rvalid, m0_rvalid} !== 2'b00 || s_rready !== 1'b0) begin err++; $display("FAIL idle_gap: s_arvalid=%b rvalid=%b s_rready=%b, want 0 00 0", s_arvalid, {m1_rvalid, m0_rvalid}, s_rready); end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 32'h10; m1_araddr = 32'h20;
        s_arready = 1; s_rvalid = 1; s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b11;
        repeat (2) @(negedge clk); #1;
        vec++; if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_araddr, m0_rdata, m1_rdata, m0_rresp, m1_rresp} !== '0) begin err++; $display("FAIL reset_outputs: some output nonzero s_arvalid=%b s_araddr=%h m0_rdata=%h", s_arvalid, s_araddr, m0_rdata); end
        reset_dut();
        #1;
        vec++; if (s_arvalid !== 1'b0 || s_araddr !== 32'h0) begin err++; $display("FAIL reset_idle: s_arvalid=%b s_araddr=%h, want 0 0", s_arvalid, s_araddr); end
    endtask

    task automatic test_single_m0();
        reset_dut();
        m0_araddr = 32'h10; m0_arvalid = 1; #1;
        vec++; if (s_arvalid !== 1'b0) begin err++; $display("FAIL single_latency: s_arvalid=%b in request cycle, want 0", s_arvalid); end
        @(negedge clk);
        slave_txn(0, 32'h10, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    endtask

    task automatic test_tie();
        reset_dut();
        m0_araddr = 32'h10; m1_araddr = 32'h20; m0_arvalid = 1; m1_arvalid = 1;
        @(negedge clk);
        slave_txn(0, 32'h10, 32'h1111_0000, 2'b00, 0, 0, 0);
        slave_txn(1, 32'h20, 32'h2222_0000, 2'b00, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        m0_arvalid = 1; m1_arvalid = 1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a = 32'h100 + 32'(i * 4);
            if (i % 2 == 1) m1_araddr = a; else m0_araddr = a;
            slave_txn(i % 2 == 1, a, 32'hC0DE_0000 + 32'(i), 2'b00, 0, 0, i < 4);
            if (i < 5) begin
                if (i % 2 == 1) m0_araddr = 32'h100 + 32'((i + 1) * 4);
                else m1_araddr = 32'h100 + 32'((i + 1) * 4);
            end
        end
    endtask

    task automatic test_stalls();
        reset_dut();
        m1_araddr = 32'h30; m1_arvalid = 1;
        @(negedge clk);
        m0_araddr = 32'h40; m0_arvalid = 1;
        slave_txn(1, 32'h30, 32'h5A5A_A5A5, 2'b00, 3, 2, 0);
        slave_txn(0, 32'h40, 32'h0BAD_F00D, 2'b00, 0, 0, 0);
    endtask

    task automatic test_slverr();
        m1_araddr = 32'h50; m1_arvalid = 1;
        @(negedge clk);
        slave_txn(1, 32'h50, 32'hE77E_0001, 2'b10, 1, 0, 0);
    endtask

    task automatic test_reset_mid();
        m0_araddr = 32'h54; m0_arvalid = 1;
        @(negedge clk);
        slave_txn(0, 32'h54, 32'h0000_0054, 2'b00, 0, 0, 0);
        m1_araddr = 32'h60; m1_arvalid = 1;
        @(negedge clk);
        s_arready = 1;
        @(negedge clk);
        s_arready = 0; m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h6060_6060; m1_rready = 0; #1;
        vec++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h6060_6060) begin err++; $display("FAIL mid_data: m1_rvalid=%b m1_rdata=%h, want 1 60606060", m1_rvalid, m1_rdata); end
        #1 rst = 1; #1;
        vec++; if ({m1_rvalid, m0_rvalid, s_rready, s_arvalid} !== 4'b0 || m1_rdata !== 32'h0) begin err++; $display("FAIL mid_reset: m1_rvalid=%b s_rready=%b m1_rdata=%h, want 0 0 0", m1_rvalid, s_rready, m1_rdata); end
        @(negedge clk);
        reset_dut();
        m0_araddr = 32'h70; m1_araddr = 32'h74; m0_arvalid = 1; m1_arvalid = 1;
        @(negedge clk);
        slave_txn(0, 32'h70, 32'h7070_7070, 2'b00, 0, 0, 0);
        slave_txn(1, 32'h74, 32'h7474_7474, 2'b00, 0, 0, 0);
        m1_araddr = 32'h78; m1_arvalid = 1;
        @(negedge clk);
        slave_txn(1, 32'h78, 32'h7878_7878, 2'b01, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_tie();
        test_back_to_back();
        test_stalls();
        test_slverr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
